// File: rtl/mips_multicycle_cpu_if.sv
// Observation bus of the multicycle MIPS core: PC and the data-memory write port.
interface mips_multicycle_cpu_if;
  logic [31:0] pc;
  logic [31:0] dataaddr;
  logic [31:0] writedata;
  logic        memwrite;

  modport master (output pc, dataaddr, writedata, memwrite);
  modport slave  (input  pc, dataaddr, writedata, memwrite);
endinterface

// File: rtl/mips_multicycle_cpu.sv
// Multicycle 32-bit MIPS core with a unified word memory and one shared ALU.
// Memory image is preloaded by the environment through the `mem` array.
module mips_multicycle_cpu #(
  parameter logic [31:0] PC_START  = 32'h0000_0000,
  parameter int          MEM_WORDS = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  mips_multicycle_cpu_if.master bus
);
  localparam int AW = $clog2(MEM_WORDS);

  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J = 6'h02, OP_BEQ = 6'h04, OP_BNE = 6'h05,
                         OP_ADDI = 6'h08, OP_ANDI = 6'h0c, OP_ORI = 6'h0d,
                         OP_LW = 6'h23, OP_SW = 6'h2b;
  localparam logic [5:0] F_ADD = 6'h20, F_SUB = 6'h22, F_AND = 6'h24, F_OR = 6'h25, F_SLT = 6'h2a;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
    S_RTEX, S_RTWB, S_IMMEX, S_IMMWB, S_BRANCH, S_JUMP
  } state_t;
  typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT} alu_op_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d, ir_q, ir_d, a_q, a_d, b_q, b_d;
  logic [31:0] aluout_q, aluout_d, mdr_q, mdr_d, bta_q, bta_d;
  logic        memwrite_q, memwrite_d;

  logic [31:0] mem [MEM_WORDS];
  logic [31:0] rf  [32];

  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd;
  logic [31:0] sext, zext, mem_rdata, rf_rd1, rf_rd2;
  logic [AW-1:0] mem_idx;
  logic        rf_we;
  logic [4:0]  rf_wa;
  logic [31:0] rf_wd;
  alu_op_t     alu_op;
  logic [31:0] alu_b, alu_y;

  assign op     = ir_q[31:26];
  assign rs     = ir_q[25:21];
  assign rt     = ir_q[20:16];
  assign rd     = ir_q[15:11];
  assign funct  = ir_q[5:0];
  assign sext   = {{16{ir_q[15]}}, ir_q[15:0]};
  assign zext   = {16'h0000, ir_q[15:0]};
  wire unused_shamt = ^ir_q[10:6];

  assign mem_idx   = (state_q == S_FETCH) ? pc_q[AW+1:2] : aluout_q[AW+1:2];
  assign mem_rdata = mem[mem_idx];
  assign rf_rd1    = (rs == 5'd0) ? 32'h0 : rf[rs];
  assign rf_rd2    = (rt == 5'd0) ? 32'h0 : rf[rt];

  always_comb begin
    alu_op = ALU_ADD;
    alu_b  = sext;
    if (state_q == S_RTEX) begin
      alu_b = b_q;
      case (funct)
        F_SUB:   alu_op = ALU_SUB;
        F_AND:   alu_op = ALU_AND;
        F_OR:    alu_op = ALU_OR;
        F_SLT:   alu_op = ALU_SLT;
        default: alu_op = ALU_ADD;
      endcase
    end else if (state_q == S_IMMEX) begin
      case (op)
        OP_ANDI: begin alu_op = ALU_AND; alu_b = zext; end
        OP_ORI:  begin alu_op = ALU_OR;  alu_b = zext; end
        default: alu_op = ALU_ADD;
      endcase
    end
    case (alu_op)
      ALU_SUB: alu_y = a_q - alu_b;
      ALU_AND: alu_y = a_q & alu_b;
      ALU_OR:  alu_y = a_q | alu_b;
      ALU_SLT: alu_y = {31'h0, $signed(a_q) < $signed(alu_b)};
      default: alu_y = a_q + alu_b;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    a_d        = a_q;
    b_d        = b_q;
    aluout_d   = aluout_q;
    mdr_d      = mdr_q;
    bta_d      = bta_q;
    memwrite_d = 1'b0;
    rf_we      = 1'b0;
    rf_wa      = rt;
    rf_wd      = aluout_q;
    case (state_q)
      S_FETCH: begin
        ir_d    = mem_rdata;
        pc_d    = pc_q + 32'd4;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        a_d   = rf_rd1;
        b_d   = rf_rd2;
        bta_d = pc_q + {sext[29:0], 2'b00};
        case (op)
          OP_LW, OP_SW:            state_d = S_MEMADR;
          OP_RTYPE:                state_d = (funct inside {F_ADD, F_SUB, F_AND, F_OR, F_SLT})
                                             ? S_RTEX : S_FETCH;
          OP_ADDI, OP_ANDI, OP_ORI: state_d = S_IMMEX;
          OP_BEQ, OP_BNE:          state_d = S_BRANCH;
          OP_J:                    state_d = S_JUMP;
          default:                 state_d = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        aluout_d = alu_y;
        if (op == OP_SW) begin
          state_d    = S_MEMWR;
          memwrite_d = 1'b1;
        end else begin
          state_d = S_MEMRD;
        end
      end
      S_MEMRD: begin mdr_d = mem_rdata; state_d = S_MEMWB; end
      S_MEMWB: begin rf_we = 1'b1; rf_wd = mdr_q; state_d = S_FETCH; end
      S_MEMWR: state_d = S_FETCH;
      S_RTEX:  begin aluout_d = alu_y; state_d = S_RTWB; end
      S_RTWB:  begin rf_we = 1'b1; rf_wa = rd; state_d = S_FETCH; end
      S_IMMEX: begin aluout_d = alu_y; state_d = S_IMMWB; end
      S_IMMWB: begin rf_we = 1'b1; state_d = S_FETCH; end
      S_BRANCH: begin
        // beq takes on equal, bne on unequal
        if ((a_q == b_q) ^ (op == OP_BNE)) pc_d = bta_q;
        state_d = S_FETCH;
      end
      S_JUMP: begin
        pc_d    = {pc_q[31:28], ir_q[25:0], 2'b00};
        state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_FETCH;
      pc_q       <= PC_START;
      ir_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      aluout_q   <= '0;
      mdr_q      <= '0;
      bta_q      <= '0;
      memwrite_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      a_q        <= a_d;
      b_q        <= b_d;
      aluout_q   <= aluout_d;
      mdr_q      <= mdr_d;
      bta_q      <= bta_d;
      memwrite_q <= memwrite_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)                              rf[0]     <= '0;
    else if (rf_we && (rf_wa != 5'd0))      rf[rf_wa] <= rf_wd;
  end

  // Reset landing on the MEMWR edge cancels the store.
  always @(posedge clk) begin
    if (memwrite_q && !reset) mem[aluout_q[AW+1:2]] <= b_q;
  end

  assign bus.pc        = pc_q;
  assign bus.dataaddr  = aluout_q;
  assign bus.writedata = b_q;
  assign bus.memwrite  = memwrite_q;
endmodule

// File: tb/tb_mips_multicycle_cpu.sv
// Directed bench for mips_multicycle_cpu: programs preloaded into the memory array.
module tb_mips_multicycle_cpu;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mips_multicycle_cpu_if bus ();
  mips_multicycle_cpu #(.PC_START(32'h0), .MEM_WORDS(64)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic hold_and_fill(input logic [31:0] fill);
    reset = 1'b1;
    tick(1);
    for (int i = 0; i < 64; i++) dut.mem[i] = fill;
  endtask

  task automatic release_rst(input string tag);
    tick(1);
    chk({tag, "_rst_pc"}, bus.pc, 32'h0);
    chk({tag, "_rst_mw"}, {31'h0, bus.memwrite}, 32'h0);
    chk({tag, "_rst_da"}, bus.dataaddr, 32'h0);
    chk({tag, "_rst_wd"}, bus.writedata, 32'h0);
    chk({tag, "_rst_st"}, 32'(dut.state_q), 32'h0);
    reset = 1'b0;
  endtask

  initial begin
    int hits, at;
    logic [31:0] da, wd;

    // straight-line addi $2,$0,1
    hold_and_fill(32'h2002_0001);
    release_rst("addi");
    tick(4);
    chk("addi_pc4", bus.pc, 32'd4);
    chk("addi_rf2", dut.rf[2], 32'd1);
    tick(8);
    chk("addi_pc12", bus.pc, 32'd12);
    chk("addi_da", bus.dataaddr, 32'd1);
    chk("addi_wd", bus.writedata, 32'd1);

    // addi $4,$0,5 ; sw $4,0x40($0) ; lw $5,0x40($0)
    hold_and_fill(32'h0);
    dut.mem[0] = 32'h2004_0005;
    dut.mem[1] = 32'hAC04_0040;
    dut.mem[2] = 32'h8C05_0040;
    release_rst("mem");
    hits = 0; at = 0; da = '0; wd = '0;
    for (int c = 1; c <= 13; c++) begin
      tick(1);
      if (bus.memwrite) begin
        hits++; at = c; da = bus.dataaddr; wd = bus.writedata;
      end
    end
    chk("sw_pulses", 32'(hits), 32'd1);
    chk("sw_cycle", 32'(at), 32'd7);
    chk("sw_addr", da, 32'h40);
    chk("sw_data", wd, 32'd5);
    chk("sw_mem", dut.mem[16], 32'd5);
    chk("lw_rf5", dut.rf[5], 32'd5);
    chk("lw_pc", bus.pc, 32'd12);

    // R-type / immediate ALU ops
    hold_and_fill(32'h0);
    dut.mem[0]  = 32'h2002_0007;  // addi $2,$0,7
    dut.mem[1]  = 32'h2003_0003;  // addi $3,$0,3
    dut.mem[2]  = 32'h0043_0822;  // sub  $1,$2,$3
    dut.mem[3]  = 32'h0062_082A;  // slt  $1,$3,$2
    dut.mem[4]  = 32'h2002_FFFF;  // addi $2,$0,-1
    dut.mem[5]  = 32'h0043_082A;  // slt  $1,$2,$3
    dut.mem[6]  = 32'h0043_3024;  // and  $6,$2,$3
    dut.mem[7]  = 32'h0043_3825;  // or   $7,$2,$3
    dut.mem[8]  = 32'h3408_8000;  // ori  $8,$0,0x8000
    dut.mem[9]  = 32'h3049_FFFF;  // andi $9,$2,0xffff
    dut.mem[10] = 32'h2000_0005;  // addi $0,$0,5
    release_rst("alu");
    tick(12); chk("sub", dut.rf[1], 32'd4);
    tick(4);  chk("slt_pos", dut.rf[1], 32'd1);
    tick(4);  chk("addi_neg", dut.rf[2], 32'hFFFF_FFFF);
    tick(4);  chk("slt_signed", dut.rf[1], 32'd1);
    tick(4);  chk("and", dut.rf[6], 32'd3);
    tick(4);  chk("or", dut.rf[7], 32'hFFFF_FFFF);
    tick(4);  chk("ori_zext", dut.rf[8], 32'h0000_8000);
    tick(4);  chk("andi_zext", dut.rf[9], 32'h0000_FFFF);
    tick(4);  chk("r0_stays0", dut.rf[0], 32'h0);
    chk("r0_da", bus.dataaddr, 32'd5);
    chk("alu_pc", bus.pc, 32'd44);

    // branches and jump
    hold_and_fill(32'h0);
    dut.mem[0]  = 32'h1000_0002;  // beq $0,$0,+2
    dut.mem[3]  = 32'h1400_0005;  // bne $0,$0,+5
    dut.mem[4]  = 32'h0800_0010;  // j 0x10
    dut.mem[16] = 32'h2002_0001;  // addi $2,$0,1
    dut.mem[17] = 32'h1440_FFFE;  // bne $2,$0,-2
    release_rst("br");
    tick(3); chk("beq_taken", bus.pc, 32'h0C);
    tick(3); chk("bne_not", bus.pc, 32'h10);
    tick(3); chk("jump", bus.pc, 32'h40);
    tick(4); chk("br_addi_pc", bus.pc, 32'h44);
    tick(3); chk("bne_back", bus.pc, 32'h40);

    // reset during MEMWR cancels the store
    hold_and_fill(32'h0);
    dut.mem[0]  = 32'h2004_0005;
    dut.mem[1]  = 32'hAC04_0040;
    dut.mem[16] = 32'h1234_5678;
    release_rst("abort");
    tick(7);
    chk("abort_mw_pre", {31'h0, bus.memwrite}, 32'd1);
    reset = 1'b1;
    tick(1);
    chk("abort_pc", bus.pc, 32'h0);
    chk("abort_mw", {31'h0, bus.memwrite}, 32'h0);
    chk("abort_da", bus.dataaddr, 32'h0);
    chk("abort_mem", dut.mem[16], 32'h1234_5678);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
